// File: rtl/power_mode_controller.sv
// Power/mode sequencer: long-press power-on, mode cycling, off request.
// Inactivity auto-off is built only when AUTO_OFF_EN is defined.
module power_mode_controller #(
  parameter int HOLD_CYCLES = 50,
  parameter int IDLE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on_req,
  input  logic       power_off_req,
  input  logic       mode_btn,
  input  logic       activity,
  output logic       power_on,
  output logic [1:0] mode,
  output logic [1:0] state,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_ARMING = 2'd1,
    S_ON     = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  if (HOLD_CYCLES < 2 || IDLE_CYCLES < 2 ||
      longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(IDLE_CYCLES) >= (longint'(1) << CNT_W))
  begin : g_bad_cfg
    $error("power_mode_controller: bad parameters");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           st_q, st_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       mode_q, mode_d;
  logic             btn_q;
  logic             btn_rise;

  assign btn_rise = mode_btn & ~btn_q;

`ifdef AUTO_OFF_EN
  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_CYCLES - 1);

  logic [CNT_W-1:0] idle_q, idle_d;
  logic             tp_q, tp_d;
  logic             idle_hit;

  assign idle_hit = ~activity & (idle_q == IDLE_LAST);
`else
  logic             act_unused;

  assign act_unused = activity;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_OFF;
      hold_q <= '0;
      mode_q <= 2'd0;
      btn_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
      mode_q <= mode_d;
      btn_q  <= mode_btn;
    end
  end

`ifdef AUTO_OFF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      tp_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tp_q   <= tp_d;
    end
  end
`endif

  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    mode_d = mode_q;
`ifdef AUTO_OFF_EN
    idle_d = idle_q;
    tp_d   = 1'b0;
`endif
    unique case (st_q)
      S_OFF: begin
        hold_d = '0;
        if (power_on_req) begin
          st_d   = S_ARMING;
          hold_d = CNT_W'(1);
        end
      end
      S_ARMING: begin
        if (!power_on_req) begin
          st_d   = S_OFF;
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          st_d   = S_ON;
          mode_d = 2'd0;
`ifdef AUTO_OFF_EN
          idle_d = '0;
`endif
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      S_ON: begin
        if (power_off_req) begin
          st_d = S_WAIT;
`ifdef AUTO_OFF_EN
        end else if (idle_hit) begin
          st_d = S_WAIT;
          tp_d = 1'b1;
`endif
        end else begin
`ifdef AUTO_OFF_EN
          if (activity || btn_rise)
            idle_d = '0;
          else if (idle_q != IDLE_LAST)
            idle_d = idle_q + CNT_W'(1);
`endif
          // Mode wraps MANUAL -> SEMI_AUTO -> AUTO -> MANUAL
          if (btn_rise)
            mode_d = (mode_q == 2'd2) ? 2'd0 :
                     mode_q + 2'd1;
        end
      end
      S_WAIT: begin
        if (!power_on_req)
          st_d = S_OFF;
      end
      default: st_d = S_OFF;
    endcase
  end

  assign power_on = (st_q == S_ON);
  assign state    = st_q;
  assign mode     = mode_q;
`ifdef AUTO_OFF_EN
  assign timeout_pulse = tp_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_power_mode_controller.sv
// Testbench for power_mode_controller: run-length reference model
// compared every cycle, plus directed literal checks.
module tb_power_mode_controller;

  localparam int HOLD = 50;
  localparam int IDLE = 200;
`ifdef AUTO_OFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, off, btn, act;
  logic       pon, tp;
  logic [1:0] mode, state;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  power_mode_controller #(
    .HOLD_CYCLES(HOLD),
    .IDLE_CYCLES(IDLE),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .power_on_req(req),
    .power_off_req(off),
    .mode_btn(btn),
    .activity(act),
    .power_on(pon),
    .mode(mode),
    .state(state),
    .timeout_pulse(tp)
  );

  // Reference: phase, length of the current button hold,
  // length of the current quiet stretch while on.
  int ms    = 0;
  int mm    = 0;
  int run   = 0;
  int quiet = 0;
  bit mtp   = 1'b0;
  bit pbtn  = 1'b0;
  bit rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms = 0; mm = 0; run = 0; quiet = 0;
      mtp = 1'b0; pbtn = 1'b0;
    end else begin
      rise = btn && !pbtn;
      mtp  = 1'b0;
      if (ms == 0) begin
        run = req ? 1 : 0;
        if (req) ms = 1;
      end else if (ms == 1) begin
        if (!req) begin
          ms = 0; run = 0;
        end else begin
          run = run + 1;
          if (run == HOLD) begin
            ms = 2; mm = 0; quiet = 0;
          end
        end
      end else if (ms == 2) begin
        if (off) ms = 3;
        else if (AUTO && !act && quiet + 1 == IDLE) begin
          ms = 3; mtp = 1'b1;
        end else begin
          quiet = (act || rise) ? 0 : quiet + 1;
          if (rise) mm = (mm + 1) % 3;
        end
      end else begin
        if (!req) ms = 0;
      end
      pbtn = btn;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_state", 32'(state), 32'(ms));
    chk("cyc_pon", 32'(pon), 32'(ms == 2));
    chk("cyc_mode", 32'(mode), 32'(mm));
    chk("cyc_tp", 32'(tp), 32'(mtp));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_pon"}, 32'(pon), 0);
    chk({tag, "_mode"}, 32'(mode), 0);
    chk({tag, "_tp"}, 32'(tp), 0);
    #1 rst_n = 1'b1;
  endtask

  task automatic press();
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp_m [4] = '{1, 2, 0, 1};

  initial begin
    rst_n = 1'b0;
    req = 1'b0; off = 1'b0; btn = 1'b0; act = 1'b0;
    #23;
    chk("reset_state", 32'(state), 0);
    chk("reset_pon", 32'(pon), 0);
    chk("reset_mode", 32'(mode), 0);
    chk("reset_tp", 32'(tp), 0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_off", 32'(state), 0);

    // Long press powers on after exactly HOLD edges
    req = 1'b1;
    tick(1);
    chk("arm_edge1", 32'(state), 1);
    tick(48);
    chk("arm_edge49_pon", 32'(pon), 0);
    tick(1);
    chk("on_edge50_pon", 32'(pon), 1);
    chk("on_edge50_state", 32'(state), 2);
    chk("on_edge50_mode", 32'(mode), 0);

    // Mode cycling, one step per rising edge
    act = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btn = 1'b1;
      tick(1);
      chk("mode_step", 32'(mode), 32'(exp_m[i]));
      btn = 1'b0;
      tick(1);
    end
    btn = 1'b1;
    tick(10);
    chk("mode_level_once", 32'(mode), 2);
    btn = 1'b0;
    tick(1);

    // Off request while button still held
    off = 1'b1;
    tick(1);
    chk("off_state", 32'(state), 3);
    chk("off_pon", 32'(pon), 0);
    chk("off_mode_kept", 32'(mode), 2);
    off = 1'b0;
    tick(3);
    chk("wait_held", 32'(state), 3);
    req = 1'b0;
    tick(1);
    chk("wait_released", 32'(state), 0);

    // Dropped hold restarts the count
    req = 1'b1;
    tick(49);
    chk("drop_pre_pon", 32'(pon), 0);
    req = 1'b0;
    tick(1);
    chk("drop_off", 32'(state), 0);
    req = 1'b1;
    tick(49);
    chk("rehold49_state", 32'(state), 1);
    tick(1);
    chk("rehold50_state", 32'(state), 2);

    // Inactivity timeout after IDLE quiet edges
    req = 1'b0; act = 1'b0;
    tick(199);
    chk("quiet199_state", 32'(state), 2);
    chk("quiet199_tp", 32'(tp), 0);
    tick(1);
    chk("quiet200_state", 32'(state), AUTO ? 3 : 2);
    chk("quiet200_tp", 32'(tp), 32'(AUTO));
    chk("quiet200_pon", 32'(pon), 32'(!AUTO));
    tick(1);
    chk("quiet201_tp", 32'(tp), 0);
    chk("quiet201_state", 32'(state), AUTO ? 0 : 2);
    off = 1'b1;
    tick(1);
    off = 1'b0;
    tick(1);
    chk("quiet_off", 32'(state), 0);

    // Activity at ON edge 150 pushes timeout to edge 350
    req = 1'b1;
    tick(50);
    chk("on_again", 32'(state), 2);
    req = 1'b0;
    tick(149);
    act = 1'b1;
    tick(1);
    act = 1'b0;
    tick(199);
    chk("delay349_state", 32'(state), 2);
    tick(1);
    chk("delay350_state", 32'(state), AUTO ? 3 : 2);
    chk("delay350_tp", 32'(tp), 32'(AUTO));
    off = 1'b1;
    tick(1);
    off = 1'b0;
    tick(2);
    chk("delay_off", 32'(state), 0);

    // Async reset mid-arming and in ON with mode 2
    req = 1'b1;
    tick(30);
    chk("arm30_state", 32'(state), 1);
    async_reset("rst_arm");
    tick(49);
    chk("post_rst49", 32'(state), 1);
    tick(1);
    chk("post_rst50", 32'(state), 2);
    act = 1'b1;
    press();
    press();
    chk("mode2_pre_rst", 32'(mode), 2);
    async_reset("rst_on");
    req = 1'b0; act = 1'b0;
    tick(3);
    chk("end_off", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
